// File: rtl/rom_wb.sv
// Wishbone B4 pipelined read-only slave in front of a synchronous ROM.
// One request per cycle; ack/err after one (out_reg=0) or two (out_reg=1) cycles.
module rom_wb #(
    parameter int size       = 'h2000,
    parameter int addr_width = $clog2(size),
    parameter int data_width = 16,
    parameter int out_reg    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [addr_width:0]   wb_adr_i,
    output logic [data_width-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    output logic [addr_width-1:0] rom_address,
    output logic                  rom_cen,
    input  logic [data_width-1:0] rom_q
);

    logic                  accept;
    logic                  req_err;

    logic                  v1_q, v1_d;
    logic                  e1_q, e1_d;
    logic                  v2_q, v2_d;
    logic                  e2_q, e2_d;
    logic [data_width-1:0] dat2_q, dat2_d;

    // Request decode: accept, classify, and drive the ROM port
    always_comb begin
        wb_stall_o  = 1'b0;
        rom_address = wb_adr_i[addr_width:1];
        accept      = wb_cyc_i & wb_stb_i & ~wb_stall_o;
        req_err     = wb_we_i | wb_adr_i[0]
                    | (32'(rom_address) >= 32'(size));
        rom_cen     = accept & ~req_err;
    end

    // Next state for both pipeline stages; dropping cyc flushes them
    always_comb begin
        v1_d   = accept;
        e1_d   = accept & req_err;
        v2_d   = v1_q & wb_cyc_i;
        e2_d   = e1_q & v1_q & wb_cyc_i;
        dat2_d = dat2_q;
        if (v1_q & ~e1_q) begin
            dat2_d = rom_q;
        end
    end

    // Pipeline registers, cleared immediately by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            v2_q   <= 1'b0;
            e2_q   <= 1'b0;
            dat2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            e1_q   <= e1_d;
            v2_q   <= v2_d;
            e2_q   <= e2_d;
            dat2_q <= dat2_d;
        end
    end

    // Termination from stage 1 or stage 2; data is zero unless acking
    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        wb_dat_o = '0;
        if (out_reg == 0) begin
            wb_ack_o = v1_q & ~e1_q & wb_cyc_i;
            wb_err_o = v1_q & e1_q & wb_cyc_i;
            if (wb_ack_o) begin
                wb_dat_o = rom_q;
            end
        end else begin
            wb_ack_o = v2_q & ~e2_q & wb_cyc_i;
            wb_err_o = v2_q & e2_q & wb_cyc_i;
            if (wb_ack_o) begin
                wb_dat_o = dat2_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_wb.sv
// Directed bench for rom_wb: three instances (out_reg=0, out_reg=1,
// reduced size) share one Wishbone master and each has its own ROM model.
module tb_rom_wb;

    logic        clock;
    logic        reset;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [13:0] adr;

    logic [15:0] dat0, dat1, dat2;
    logic        ack0, ack1, ack2;
    logic        err0, err1, err2;
    logic        stall0, stall1, stall2;
    logic [12:0] ra0, ra1, ra2;
    logic        cen0, cen1, cen2;
    logic [15:0] q0, q1, q2;

    int checks = 0;
    int errors = 0;

    rom_wb #(.size('h2000), .out_reg(0)) dut0 (
        .clock(clock), .reset(reset),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0),
        .wb_stall_o(stall0), .rom_address(ra0), .rom_cen(cen0),
        .rom_q(q0)
    );

    rom_wb #(.size('h2000), .out_reg(1)) dut1 (
        .clock(clock), .reset(reset),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1),
        .wb_stall_o(stall1), .rom_address(ra1), .rom_cen(cen1),
        .rom_q(q1)
    );

    rom_wb #(.size('h1800), .out_reg(0)) dut2 (
        .clock(clock), .reset(reset),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2),
        .wb_stall_o(stall2), .rom_address(ra2), .rom_cen(cen2),
        .rom_q(q2)
    );

    function automatic logic [15:0] rom_word(input int idx);
        if (idx == 5) return 16'hA55A;
        return 16'(idx * 'h0101 + 'h1000);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cen0) q0 <= rom_word(int'(ra0));
        if (cen1) q1 <= rom_word(int'(ra1));
        if (cen2) q2 <= rom_word(int'(ra2));
    end

    task automatic drive(input logic c, input logic s,
                         input logic w, input logic [13:0] a);
        @(posedge clock);
        #1;
        cyc = c; stb = s; we = w; adr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; cyc = 0; stb = 0; we = 0; adr = '0;
        #2;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_ack0 got %b exp 0", ack0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err0 got %b exp 0", err0); end
        checks++; if (dat0 !== 16'h0) begin errors++; $display("FAIL rst_dat0 got %h exp 0000", dat0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack1 got %b exp 0", ack1); end
        checks++; if (dat1 !== 16'h0) begin errors++; $display("FAIL rst_dat1 got %h exp 0000", dat1); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall0); end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_single;
        drive(1, 1, 0, 14'h000A);
        checks++; if (cen0 !== 1'b1) begin errors++; $display("FAIL single_cen got %b exp 1", cen0); end
        checks++; if (ra0 !== 13'd5) begin errors++; $display("FAIL single_addr got %h exp 5", ra0); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", ack0); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", ack0); end
        checks++; if (dat0 !== 16'hA55A) begin errors++; $display("FAIL single_dat got %h exp a55a", dat0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err0); end
        checks++; if (cen0 !== 1'b0) begin errors++; $display("FAIL single_cen_idle got %b exp 0", cen0); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL single_ack1 got %b exp 1", ack1); end
        checks++; if (dat1 !== 16'hA55A) begin errors++; $display("FAIL single_dat1 got %h exp a55a", dat1); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL single_ack0_once got %b exp 0", ack0); end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 7; k++) begin
            logic        ea0, ea1;
            logic [15:0] ed0, ed1;
            if (k < 4) drive(1, 1, 0, 14'(2 * k));
            else drive(1, 0, 0, 14'h0);
            ea0 = (k >= 1 && k <= 4);
            ea1 = (k >= 2 && k <= 5);
            ed0 = ea0 ? rom_word(k - 1) : 16'h0;
            ed1 = ea1 ? rom_word(k - 2) : 16'h0;
            checks++; if (ack1 !== ea1) begin errors++; $display("FAIL b2b_ack1[%0d] got %b exp %b", k, ack1, ea1); end
            checks++; if (dat1 !== ed1) begin errors++; $display("FAIL b2b_dat1[%0d] got %h exp %h", k, dat1, ed1); end
            checks++; if (ack0 !== ea0) begin errors++; $display("FAIL b2b_ack0[%0d] got %b exp %b", k, ack0, ea0); end
            checks++; if (dat0 !== ed0) begin errors++; $display("FAIL b2b_dat0[%0d] got %h exp %h", k, dat0, ed0); end
        end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_errors;
        drive(1, 1, 1, 14'h0004);
        checks++; if (cen0 !== 1'b0) begin errors++; $display("FAIL err_we_cen got %b exp 0", cen0); end
        drive(1, 1, 0, 14'h0003);
        checks++; if (cen0 !== 1'b0) begin errors++; $display("FAIL err_odd_cen got %b exp 0", cen0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_we_err got %b exp 1", err0); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL err_we_ack got %b exp 0", ack0); end
        drive(1, 1, 0, 14'h0004);
        checks++; if (cen0 !== 1'b1) begin errors++; $display("FAIL err_rd_cen got %b exp 1", cen0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_odd_err got %b exp 1", err0); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL err_odd_ack got %b exp 0", ack0); end
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL err_we_err1 got %b exp 1", err1); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL err_rd_ack got %b exp 1", ack0); end
        checks++; if (dat0 !== 16'h1202) begin errors++; $display("FAIL err_rd_dat got %h exp 1202", dat0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_rd_err got %b exp 0", err0); end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_cyc_drop;
        drive(1, 1, 0, 14'h0002);
        drive(0, 0, 0, 14'h0);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL drop_ack0 got %b exp 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL drop_ack1_n1 got %b exp 0", ack1); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL drop_ack1_n2 got %b exp 0", ack1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL drop_err1_n2 got %b exp 0", err1); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL drop_ack1_n3 got %b exp 0", ack1); end
        drive(1, 1, 0, 14'h0006);
        drive(1, 0, 0, 14'h0);
        checks++; if (dat0 !== 16'h1303) begin errors++; $display("FAIL drop_new_dat0 got %h exp 1303", dat0); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL drop_new_ack1 got %b exp 1", ack1); end
        checks++; if (dat1 !== 16'h1303) begin errors++; $display("FAIL drop_new_dat1 got %h exp 1303", dat1); end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_stb_no_cyc;
        drive(0, 1, 0, 14'h0008);
        checks++; if (cen0 !== 1'b0) begin errors++; $display("FAIL nocyc_cen got %b exp 0", cen0); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL nocyc_ack got %b exp 0", ack0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL nocyc_err got %b exp 0", err0); end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_reset_mid;
        drive(1, 1, 0, 14'h0000);
        drive(1, 1, 0, 14'h0002);
        @(posedge clock);
        #1;
        reset = 1'b1; stb = 1'b0;
        #1;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rmid_ack0 got %b exp 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rmid_ack1 got %b exp 0", ack1); end
        checks++; if (dat1 !== 16'h0) begin errors++; $display("FAIL rmid_dat1 got %h exp 0000", dat1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rmid_err1 got %b exp 0", err1); end
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b exp 0", stall1); end
        @(posedge clock);
        #2;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rmid_hold_ack1 got %b exp 0", ack1); end
        @(posedge clock);
        #1;
        reset = 1'b0; stb = 1'b1; adr = 14'h0008;
        #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rmid_rel_ack1 got %b exp 0", ack1); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL rmid_new_ack0 got %b exp 1", ack0); end
        checks++; if (dat0 !== 16'h1404) begin errors++; $display("FAIL rmid_new_dat0 got %h exp 1404", dat0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rmid_stale_ack1 got %b exp 0", ack1); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rmid_new_ack1 got %b exp 1", ack1); end
        checks++; if (dat1 !== 16'h1404) begin errors++; $display("FAIL rmid_new_dat1 got %h exp 1404", dat1); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rmid_stale_ack0 got %b exp 0", ack0); end
        drive(1, 0, 0, 14'h0);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rmid_tail_ack1 got %b exp 0", ack1); end
        drive(0, 0, 0, 14'h0);
    endtask

    task automatic test_size_limit;
        logic [15:0] w_last, w_over;
        w_last = rom_word('h17FF);
        w_over = rom_word('h1800);
        drive(1, 1, 0, 14'h2FFE);
        checks++; if (cen2 !== 1'b1) begin errors++; $display("FAIL size_last_cen got %b exp 1", cen2); end
        drive(1, 1, 0, 14'h3000);
        checks++; if (cen2 !== 1'b0) begin errors++; $display("FAIL size_over_cen got %b exp 0", cen2); end
        checks++; if (cen0 !== 1'b1) begin errors++; $display("FAIL size_full_cen got %b exp 1", cen0); end
        checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL size_last_ack got %b exp 1", ack2); end
        checks++; if (dat2 !== w_last) begin errors++; $display("FAIL size_last_dat got %h exp %h", dat2, w_last); end
        drive(1, 0, 0, 14'h0);
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL size_over_err got %b exp 1", err2); end
        checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL size_over_ack got %b exp 0", ack2); end
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL size_full_ack got %b exp 1", ack0); end
        checks++; if (dat0 !== w_over) begin errors++; $display("FAIL size_full_dat got %h exp %h", dat0, w_over); end
        drive(0, 0, 0, 14'h0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_cyc_drop();
        test_stb_no_cyc();
        test_reset_mid();
        test_size_limit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
